ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive equal CLOCK_50 samples required before a PS/2 clock level is accepted (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 100000, meaning CLOCK_50 cycles without a falling PS/2 clock edge before an in-progress frame is abandoned (2 ms at 50 MHz).
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to CLOCK_50.
REQ-006 SHALL have port ps2_dat  input  1  raw PS/2 data line, asynchronous to CLOCK_50.
REQ-007 SHALL have port ps2_data  output  8  last correctly received scan-code byte.
REQ-008 SHALL have port ps2_data_clk  output  1  one-cycle strobe marking a new valid ps2_data.
REQ-009 SHALL have port frame_err  output  1  one-cycle strobe marking a discarded frame.

Function
REQ-010 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchronizer before any other use.
REQ-011 SHALL filter synchronized ps2_clk: accepted level changes only after FILTER_LEN consecutive equal samples; filtered level resets to 1.
REQ-012 SHALL detect a falling edge as filtered clock 1 -> 0; one edge event lasts exactly one cycle.
REQ-013 SHALL sample synchronized ps2_dat in the cycle of each falling-edge event.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on edge with data 0 (start bit) -> DATA, bit counter = 0; edge with data 1 -> stay IDLE, no error.
REQ-016 DATA: each edge shifts data into bit[counter], LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: on edge, store parity bit -> STOP.
REQ-018 STOP: on edge, if stop bit = 1 and odd parity over 8 data bits plus parity bit holds -> IDLE with ps2_data updated and ps2_data_clk = 1 in the next cycle; else -> IDLE with frame_err = 1 in the next cycle, ps2_data unchanged.
REQ-019 Latency: ps2_data_clk SHALL assert exactly one CLOCK_50 cycle after the stop-bit edge event; ps2_data SHALL be valid in that same cycle and held until the next strobe.
REQ-020 ps2_data_clk and frame_err SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-021 SHALL count cycles since the last edge event while not IDLE; on reaching TIMEOUT -> IDLE, frame_err = 1 for one cycle, partial byte discarded.
REQ-022 Timeout counter SHALL be cleared on every edge event and held at 0 in IDLE.
REQ-023 Back-to-back frames (start edge immediately after stop edge) SHALL both be received; no dead time required.
REQ-024 Byte 8'hF0 and 8'hE0 SHALL be delivered like any other byte; no scan-code interpretation here.

Reset
REQ-025 On rst_n = 0 SHALL immediately: state IDLE, ps2_data = 8'h00, ps2_data_clk = 0, frame_err = 0, counters 0, synchronizers and filtered clock = 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame without any strobe; first edge after release is treated from IDLE.

Configuration
REQ-027 Macro PS2_RECEIVER_PARITY_CHECK_EN defined: parity SHALL be checked per REQ-018.
REQ-028 Macro undefined: parity bit SHALL still be consumed but ignored; only stop bit = 0 or timeout raises frame_err.

Verification
REQ-029 Frame 0x1C, parity 0, stop 1, 12 kHz PS/2 clock -> one ps2_data_clk pulse, ps2_data = 8'h1C, frame_err stays 0.
REQ-030 Frames F0 then 1C back-to-back -> two strobes, ps2_data 8'hF0 then 8'h1C, no error.
REQ-031 Frame 0x1C with parity 1 -> macro defined: frame_err pulse, ps2_data unchanged, no strobe; macro undefined: strobe, ps2_data = 8'h1C.
REQ-032 Stop bit driven 0 -> frame_err pulse, no strobe, next good frame 0x29 -> ps2_data = 8'h29.
REQ-033 Clock stops after 5 data bits for > TIMEOUT cycles -> single frame_err pulse at TIMEOUT, next frame 0x5A received correctly.
REQ-034 3-cycle low glitches on ps2_clk between edges and rst_n pulsed low mid-frame -> no extra bits shifted, no strobe from aborted frame, outputs at reset values immediately.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: synchronizer, clock filter, frame FSM.
// Define PS2_RECEIVER_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_data,
    output logic       ps2_data_clk,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic [7:0] filt_cnt;
    logic       filt, filt_d;
    logic       fall;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, sh_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0] data_n;
    logic       strb_n, err_n;
    logic       frame_ok;
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
    logic       par, par_n;
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_cnt <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
            filt_d <= filt;
            // Only a run of FILTER_LEN samples at the new level flips filt
            if (clk_s2 == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                filt     <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    assign fall = filt_d & ~filt;

`ifdef PS2_RECEIVER_PARITY_CHECK_EN
    assign frame_ok = dat_s2 & (^{shreg, par});
`else
    assign frame_ok = dat_s2;
`endif

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        tmo_n   = tmo;
        data_n  = ps2_data;
        strb_n  = 1'b0;
        err_n   = 1'b0;
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: begin
                tmo_n = '0;
                if (fall && !dat_s2) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_n[bit_cnt] = dat_s2;
                    bit_n         = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
                    par_n = dat_s2;
`endif
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (frame_ok) begin
                        data_n = shreg;
                        strb_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Watchdog against a device that stops clocking mid-frame
        if (state != IDLE) begin
            if (fall) begin
                tmo_n = '0;
            end else if (tmo == TW'(TIMEOUT - 1)) begin
                state_n = IDLE;
                tmo_n   = '0;
                err_n   = 1'b1;
            end else begin
                tmo_n = tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            tmo          <= '0;
            ps2_data     <= 8'h00;
            ps2_data_clk <= 1'b0;
            frame_err    <= 1'b0;
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_n;
            shreg        <= sh_n;
            tmo          <= tmo_n;
            ps2_data     <= data_n;
            ps2_data_clk <= strb_n;
            frame_err    <= err_n;
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
            par          <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomized self-checking bench for ps2_receiver against a frame-level model.
// Honours PS2_RECEIVER_PARITY_CHECK_EN the same way as the design.
module tb_ps2_receiver;

    localparam int F = 6;
    localparam int T = 2000;
    localparam int H = 40;
    localparam int LAT = F + 3;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_data;
    logic       ps2_data_clk;
    logic       frame_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int strb_cnt = 0;
    int err_cnt = 0;
    int last_strb_cyc = 0;
    int last_err_cyc = 0;
    int stop_cyc = 0;
    int last_fall_cyc = 0;
    logic [7:0] exp_data;

    ps2_receiver #(.FILTER_LEN(F), .TIMEOUT(T)) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .ps2_data(ps2_data),
        .ps2_data_clk(ps2_data_clk),
        .frame_err(frame_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    always @(negedge CLOCK_50) begin
        if (rst_n) begin
            if (ps2_data_clk || frame_err) begin
                n_checks++;
                if (ps2_data_clk && frame_err) begin
                    n_fail++;
                    $display("FAIL exclusive: strobe=%b err=%b both high at cyc %0d",
                             ps2_data_clk, frame_err, cyc);
                end
            end
            if (ps2_data_clk) begin
                strb_cnt++;
                last_strb_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
        end
    end

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic exp_ok(input logic [7:0] b, input logic p, input logic s);
`ifdef PS2_RECEIVER_PARITY_CHECK_EN
        return s && ((^b) ^ p);
`else
        return s;
`endif
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input logic glitch);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            if (glitch) begin
                repeat (H / 2) @(negedge CLOCK_50);
                ps2_clk = 1'b0;
                repeat (3) @(negedge CLOCK_50);
                ps2_clk = 1'b1;
                repeat (H - H / 2 - 3) @(negedge CLOCK_50);
            end else begin
                repeat (H) @(negedge CLOCK_50);
            end
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge CLOCK_50);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              input logic glitch);
        send_bits({s, p, b, 1'b0}, 11, glitch);
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        n_checks++;
        if (ps2_data !== 8'h00 || ps2_data_clk !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: data=%h strb=%b err=%b want 00/0/0",
                     ps2_data, ps2_data_clk, frame_err);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        n_checks++;
        if (ps2_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 00", ps2_data);
        end
        n_checks++;
        if (strb_cnt !== 0 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_quiet: strobes %0d errs %0d want 0/0", strb_cnt, err_cnt);
        end
        exp_data = 8'h00;
    endtask

    task automatic test_single();
        int s0 = strb_cnt;
        int e0 = err_cnt;
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h1C;
        n_checks++;
        if (strb_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL single_counts: strobes %0d errs %0d want 1/0",
                     strb_cnt - s0, err_cnt - e0);
        end
        n_checks++;
        if (ps2_data !== exp_data) begin
            n_fail++;
            $display("FAIL single_data: got %h want %h", ps2_data, exp_data);
        end
        n_checks++;
        if (last_strb_cyc - stop_cyc !== LAT) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want %0d",
                     last_strb_cyc - stop_cyc, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int s0 = strb_cnt;
        int e0 = err_cnt;
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
        n_checks++;
        if (ps2_data !== 8'hF0 || strb_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_first: data %h strobes %0d want F0/1",
                     ps2_data, strb_cnt - s0);
        end
        send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h1C;
        n_checks++;
        if (ps2_data !== exp_data || strb_cnt - s0 !== 2 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: data %h strobes %0d errs %0d want 1C/2/0",
                     ps2_data, strb_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_bad_parity();
        int s0;
        int e0;
        logic ok;
        send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
        exp_data = 8'hF0;
        s0 = strb_cnt;
        e0 = err_cnt;
        ok = exp_ok(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        if (ok) exp_data = 8'h1C;
        n_checks++;
        if (strb_cnt - s0 !== int'(ok) || err_cnt - e0 !== int'(!ok)) begin
            n_fail++;
            $display("FAIL parity_counts: strobes %0d errs %0d want %0d/%0d",
                     strb_cnt - s0, err_cnt - e0, int'(ok), int'(!ok));
        end
        n_checks++;
        if (ps2_data !== exp_data) begin
            n_fail++;
            $display("FAIL parity_data: got %h want %h", ps2_data, exp_data);
        end
    endtask

    task automatic test_stop_err();
        int s0 = strb_cnt;
        int e0 = err_cnt;
        send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        n_checks++;
        if (strb_cnt - s0 !== 0 || err_cnt - e0 !== 1 || ps2_data !== exp_data) begin
            n_fail++;
            $display("FAIL stop_err: strobes %0d errs %0d data %h want 0/1/%h",
                     strb_cnt - s0, err_cnt - e0, ps2_data, exp_data);
        end
        n_checks++;
        if (last_err_cyc - stop_cyc !== LAT) begin
            n_fail++;
            $display("FAIL stop_err_latency: got %0d want %0d",
                     last_err_cyc - stop_cyc, LAT);
        end
        send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h29;
        n_checks++;
        if (ps2_data !== exp_data || strb_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL stop_recover: data %h strobes %0d want 29/1",
                     ps2_data, strb_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int s0 = strb_cnt;
        int e0 = err_cnt;
        send_bits({3'b111, 8'h5A, 1'b0}, 6, 1'b0);
        repeat (T + 200) @(negedge CLOCK_50);
        n_checks++;
        if (err_cnt - e0 !== 1 || strb_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_counts: errs %0d strobes %0d want 1/0",
                     err_cnt - e0, strb_cnt - s0);
        end
        n_checks++;
        if (last_err_cyc - last_fall_cyc !== F + 3 + T) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d want %0d",
                     last_err_cyc - last_fall_cyc, F + 3 + T);
        end
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h5A;
        n_checks++;
        if (ps2_data !== exp_data || strb_cnt - s0 !== 1 || err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_recover: data %h strobes %0d errs %0d want 5A/1/1",
                     ps2_data, strb_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_glitch_reset();
        int s0 = strb_cnt;
        int e0 = err_cnt;
        send_frame(8'h3C, odd_par(8'h3C), 1'b1, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h3C;
        n_checks++;
        if (ps2_data !== exp_data || strb_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL glitch_frame: data %h strobes %0d errs %0d want 3C/1/0",
                     ps2_data, strb_cnt - s0, err_cnt - e0);
        end
        send_bits({3'b111, 8'hA5, 1'b0}, 5, 1'b1);
        repeat (7) @(negedge CLOCK_50);
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        n_checks++;
        if (ps2_data !== exp_data || ps2_data_clk !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: data %h strb %b err %b want 00/0/0",
                     ps2_data, ps2_data_clk, frame_err);
        end
        repeat (4) @(negedge CLOCK_50);
        rst_n = 1'b1;
        s0 = strb_cnt;
        e0 = err_cnt;
        repeat (30) @(negedge CLOCK_50);
        send_frame(8'h66, odd_par(8'h66), 1'b1, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        exp_data = 8'h66;
        n_checks++;
        if (ps2_data !== exp_data || strb_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL after_reset: data %h strobes %0d errs %0d want 66/1/0",
                     ps2_data, strb_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic p, s, ok;
            int s0, e0, gap;
            b   = 8'($urandom);
            p   = odd_par(b) ^ ($urandom_range(0, 3) == 0);
            s   = ($urandom_range(0, 5) != 0);
            gap = (k % 2 == 0) ? 0 : int'($urandom_range(1, 50));
            ok  = exp_ok(b, p, s);
            s0  = strb_cnt;
            e0  = err_cnt;
            send_frame(b, p, s, 1'b0);
            if (ok) exp_data = b;
            n_checks++;
            if (strb_cnt - s0 !== int'(ok) || err_cnt - e0 !== int'(!ok)
                || ps2_data !== exp_data) begin
                n_fail++;
                $display("FAIL random_%0d: b=%h p=%b s=%b strobes %0d errs %0d data %h want %0d/%0d/%h",
                         k, b, p, s, strb_cnt - s0, err_cnt - e0, ps2_data,
                         int'(ok), int'(!ok), exp_data);
            end
            repeat (gap) @(negedge CLOCK_50);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_parity();
        test_stop_err();
        test_timeout();
        test_glitch_reset();
        test_random();
        repeat (10) @(negedge CLOCK_50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
